// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M multi-cycle divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_STATE_IDLE = 2'd0,
    DIV_STATE_CALC = 2'd1,
    DIV_STATE_END  = 2'd2
  } div_state_e;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  localparam logic [4:0] DIV_ITER_LAST = 5'd31;

  localparam logic Enable  = 1'b1;
  localparam logic Disable = 1'b0;

  function automatic logic [31:0] neg_if(
    input logic        neg,
    input logic [31:0] v
  );
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle; zero divisor and signed overflow skip CALC.
module div
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        flush_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic [4:0]  reg_waddr_i,
  output logic        div_busy_o,
  output logic        ready_o,
  output logic [31:0] result_o,
  output logic [4:0]  reg_waddr_o
);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  rd_q, rd_d;
  logic        rsel_q, rsel_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;

  logic        sgn;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [31:0] quo_nx;
  logic [31:0] rem_nx;
  logic        unused_op;

  assign unused_op = op_i[2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    res_d   = res_q;
    rd_d    = rd_q;
    rsel_d  = rsel_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    sgn     = ~op_i[0];
    // Borrow out of the 33-bit trial subtract picks the quotient bit.
    rem_sh  = {rem_q, dvd_q[31]};
    diff    = rem_sh - {1'b0, dvs_q};
    quo_nx  = {dvd_q[30:0], ~diff[32]};
    rem_nx  = diff[32] ? rem_sh[31:0] : diff[31:0];

    unique case (state_q)
      DIV_STATE_IDLE: begin
        if (start_i && !flush_i) begin
          rd_d   = reg_waddr_i;
          rsel_d = op_i[1];
          negq_d = sgn & (dividend_i[31] ^ divisor_i[31]);
          negr_d = sgn & dividend_i[31];
          if (divisor_i == 32'd0) begin
            state_d = DIV_STATE_END;
            res_d   = op_i[1] ? dividend_i : 32'hFFFF_FFFF;
          end else if (sgn && dividend_i == 32'h8000_0000
                       && divisor_i == 32'hFFFF_FFFF) begin
            state_d = DIV_STATE_END;
            res_d   = op_i[1] ? 32'd0 : 32'h8000_0000;
          end else begin
            dvd_d   = neg_if(negr_d, dividend_i);
            dvs_d   = neg_if(sgn & divisor_i[31], divisor_i);
            rem_d   = 32'd0;
            cnt_d   = 5'd0;
            state_d = DIV_STATE_CALC;
          end
        end
      end
      DIV_STATE_CALC: begin
        dvd_d = quo_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q + 5'd1;
        if (flush_i) begin
          state_d = DIV_STATE_IDLE;
        end else if (cnt_q == DIV_ITER_LAST) begin
          state_d = DIV_STATE_END;
          res_d   = rsel_q ? neg_if(negr_q, rem_nx)
                           : neg_if(negq_q, quo_nx);
        end
      end
      DIV_STATE_END: state_d = DIV_STATE_IDLE;
      default:       state_d = DIV_STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_STATE_IDLE;
      cnt_q   <= 5'd0;
      dvd_q   <= 32'd0;
      dvs_q   <= 32'd0;
      rem_q   <= 32'd0;
      res_q   <= 32'd0;
      rd_q    <= 5'd0;
      rsel_q  <= Disable;
      negq_q  <= Disable;
      negr_q  <= Disable;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
      rsel_q  <= rsel_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign div_busy_o  = (state_q != DIV_STATE_IDLE);
  assign ready_o     = (state_q == DIV_STATE_END);
  assign result_o    = ready_o ? res_q : 32'd0;
  assign reg_waddr_o = ready_o ? rd_q : 5'd0;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: vector table, random ops vs a
// reference model, and flush/busy/reset sequences.
module tb_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] dividend_i = 32'd0;
  logic [31:0] divisor_i = 32'd0;
  logic [4:0]  reg_waddr_i = 5'd0;
  logic        div_busy_o;
  logic        ready_o;
  logic [31:0] result_o;
  logic [4:0]  reg_waddr_o;

  div dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .flush_i     (flush_i),
    .op_i        (op_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .reg_waddr_i (reg_waddr_i),
    .div_busy_o  (div_busy_o),
    .ready_o     (ready_o),
    .result_o    (result_o),
    .reg_waddr_o (reg_waddr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  vec_t vecs[14];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sbv, q, r;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
    end else begin
      sa  = longint'({32'd0, a});
      sbv = longint'({32'd0, b});
    end
    q = sa / sbv;
    r = sa % sbv;
    return op[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Start is sampled at the posedge inside this task (edge N).
  task automatic drive(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    start_i     = 1'b1;
    op_i        = op;
    dividend_i  = a;
    divisor_i   = b;
    reg_waddr_i = rd;
    @(posedge clk);
    #1;
    start_i     = 1'b0;
    dividend_i  = $urandom;
    divisor_i   = $urandom;
    reg_waddr_i = 5'($urandom);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] res, input int lat);
    exp_t e;
    e.res = res;
    e.rd  = rd;
    e.lat = lat;
    sb.push_back(e);
    drive(op, a, b, rd);
  endtask

  task automatic collect(input string name, input int k0);
    int          lat = 0;
    logic [31:0] res = 32'd0;
    logic [4:0]  rd = 5'd0;
    exp_t        e;
    for (int k = k0; k <= 40; k++) begin
      @(negedge clk);
      if (k == k0) chk({name, " busy"}, 32'(div_busy_o), 32'd1);
      if (ready_o) begin
        lat = k;
        res = result_o;
        rd  = reg_waddr_o;
        break;
      end
    end
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      chk({name, " lat"}, 32'(lat), 32'(e.lat));
      chk({name, " res"}, res, e.res);
      chk({name, " rd"}, 32'(rd), 32'(e.rd));
    end
    @(negedge clk);
    chk({name, " ready drop"}, 32'(ready_o), 32'd0);
    chk({name, " busy drop"}, 32'(div_busy_o), 32'd0);
  endtask

  task automatic watch_no_ready(input string name, input int n);
    int seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (ready_o) seen++;
    end
    chk(name, 32'(seen), 32'd0);
  endtask

  task automatic chk_zero(input string name);
    chk({name, " busy"}, 32'(div_busy_o), 32'd0);
    chk({name, " ready"}, 32'(ready_o), 32'd0);
    chk({name, " result"}, result_o, 32'd0);
    chk({name, " rd"}, 32'(reg_waddr_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{3'b101, 32'd100,        32'd7,          5'd3,  32'd14,         33};
    vecs[1]  = '{3'b111, 32'd100,        32'd7,          5'd4,  32'd2,          33};
    vecs[2]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,          5'd5,  32'hFFFF_FFFD,  33};
    vecs[3]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF,  33};
    vecs[4]  = '{3'b101, 32'h1234,       32'd0,          5'd7,  32'hFFFF_FFFF,  1};
    vecs[5]  = '{3'b111, 32'h1234,       32'd0,          5'd8,  32'h1234,       1};
    vecs[6]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'h8000_0000,  1};
    vecs[7]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'd0,          1};
    vecs[8]  = '{3'b100, 32'd7,          32'd0,          5'd11, 32'hFFFF_FFFF,  1};
    vecs[9]  = '{3'b110, 32'hFFFF_FFF9,  32'd0,          5'd12, 32'hFFFF_FFF9,  1};
    vecs[10] = '{3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'd0,          33};
    vecs[11] = '{3'b101, 32'hFFFF_FFFF,  32'd1,          5'd14, 32'hFFFF_FFFF,  33};
    vecs[12] = '{3'b110, 32'd7,          32'hFFFF_FFFE,  5'd15, 32'd1,          33};
    vecs[13] = '{3'b100, 32'd7,          32'hFFFF_FFFE,  5'd31, 32'hFFFF_FFFD,  33};

    #1;
    chk_zero("reset");
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
            vecs[i].res, vecs[i].lat);
      collect($sformatf("vec%0d", i), 1);
    end

    for (int i = 0; i < 8; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      logic [4:0]  rd;
      op = {1'b1, 2'($urandom)};
      a  = $urandom;
      b  = (i % 3 == 0) ? $urandom_range(1, 100) : $urandom;
      rd = 5'($urandom);
      issue(op, a, b, rd, ref_div(op, a, b), ref_lat(op, a, b));
      collect($sformatf("rnd%0d", i), 1);
    end

    // Flush sampled at edge N+10 kills the divide.
    drive(3'b101, 32'd1000, 32'd3, 5'd1);
    repeat (9) @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("flush busy", 32'(div_busy_o), 32'd0);
    watch_no_ready("flush no ready", 40);
    issue(3'b101, 32'd9, 32'd3, 5'd2, 32'd3, 33);
    collect("after flush", 1);

    // Flush together with start in IDLE: nothing accepted.
    @(negedge clk);
    start_i    = 1'b1;
    flush_i    = 1'b1;
    op_i       = 3'b101;
    dividend_i = 32'd1;
    divisor_i  = 32'd1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    flush_i = 1'b0;
    @(negedge clk);
    chk("flush+start busy", 32'(div_busy_o), 32'd0);
    watch_no_ready("flush+start no ready", 5);

    // Start while busy is ignored; first result unchanged.
    issue(3'b101, 32'd100, 32'd7, 5'd17, 32'd14, 33);
    repeat (4) @(posedge clk);
    #1;
    start_i     = 1'b1;
    op_i        = 3'b111;
    dividend_i  = 32'd55;
    divisor_i   = 32'd5;
    reg_waddr_i = 5'd9;
    @(posedge clk);
    #1 start_i = 1'b0;
    collect("busy start", 6);
    watch_no_ready("busy start no 2nd", 40);

    // Asynchronous reset in the middle of CALC.
    drive(3'b101, 32'hFFFF, 32'd3, 5'd20);
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("mid reset");
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_ready("mid reset no ready", 40);
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd21, 32'hFFFF_FFFD, 33);
    collect("after reset", 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
